// File: rtl/latch_wr_arbiter_pkg.sv
// Shared types and helpers for the latch write arbiter: FSM state encoding and
// the width of the single phase down-counter.
package latch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_OPEN  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_ACK   = 3'd4
    } state_t;

    // The counter holds (cycles - 1), so it needs clog2 of the longest phase.
    function automatic int cnt_width(input int s_cyc, input int o_cyc, input int h_cyc);
        int m;
        m = s_cyc;
        if (o_cyc > m) m = o_cyc;
        if (h_cyc > m) m = h_cyc;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/latch_wr_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr wins.
// The pointer register lives with the FSM in the parent.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    int   pos;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr) + k) % N;
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = PW'(pos);
            end
        end
    end

endmodule

// File: rtl/latch_wr_arbiter.sv
// Serialises requester writes onto a bank of level-sensitive latches with a
// SETUP -> OPEN -> HOLD -> ACK window so data is stable around every enable.
module latch_wr_arbiter
    import latch_ctrl_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int NLATCH    = 4,
    parameter int DW        = 8,
    parameter int AW        = 2,
    parameter int SETUP_CYC = 1,
    parameter int OPEN_CYC  = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      ack,
    output logic                 err,
    output logic                 busy,
    output logic [DW-1:0]        lat_d,
    output logic [NLATCH-1:0]    lat_en
);

    localparam int CW = cnt_width(SETUP_CYC, OPEN_CYC, HOLD_CYC);
    localparam int PW = $clog2(NREQ);
    localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] OPEN_LOAD  = CW'(OPEN_CYC - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYC - 1);

    state_t             state_reg, state_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [PW-1:0]      ptr_reg, ptr_next;
    logic [PW-1:0]      win_reg, win_next;
    logic [AW-1:0]      addr_cap_reg, addr_cap_next;
    logic               err_rec_reg, err_rec_next;
    logic [NREQ-1:0]    ack_reg, ack_next;
    logic               err_reg, err_next;
    logic               busy_reg, busy_next;
    logic [DW-1:0]      lat_d_reg, lat_d_next;
    logic [NLATCH-1:0]  lat_en_reg, lat_en_next;

    logic [NREQ-1:0]    gnt;
    logic [PW-1:0]      gnt_idx;
    logic [DW-1:0]      wdata_sel;
    logic [AW-1:0]      addr_sel;
    logic [NLATCH-1:0]  en_decode;
    logic               addr_oor;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
        .req (req),
        .ptr (ptr_reg),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    // One-hot AND-OR mux of the winner's address and data.
    always_comb begin
        wdata_sel = '0;
        addr_sel  = '0;
        for (int i = 0; i < NREQ; i++) begin
            wdata_sel = wdata_sel | ({DW{gnt[i]}} & wdata[i*DW +: DW]);
            addr_sel  = addr_sel  | ({AW{gnt[i]}} & addr[i*AW +: AW]);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NLATCH; gi++) begin : g_en_decode
            assign en_decode[gi] = (addr_cap_reg == AW'(gi));
        end
    endgenerate

    assign addr_oor = ({{(32-AW){1'b0}}, addr_cap_reg} >= 32'(NLATCH));

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        ptr_next      = ptr_reg;
        win_next      = win_reg;
        addr_cap_next = addr_cap_reg;
        err_rec_next  = err_rec_reg;
        lat_d_next    = lat_d_reg;
        ack_next      = '0;
        err_next      = 1'b0;
        lat_en_next   = '0;
        case (state_reg)
            ST_IDLE: begin
                if (|req) begin
                    state_next    = ST_SETUP;
                    win_next      = gnt_idx;
                    addr_cap_next = addr_sel;
                    lat_d_next    = wdata_sel;
                    cnt_next      = SETUP_LOAD;
                end
            end
            ST_SETUP: begin
                if (cnt_reg == '0) begin
                    state_next   = ST_OPEN;
                    cnt_next     = OPEN_LOAD;
                    lat_en_next  = en_decode;
                    err_rec_next = addr_oor;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_OPEN: begin
                if (cnt_reg == '0) begin
                    state_next = ST_HOLD;
                    cnt_next   = HOLD_LOAD;
                end else begin
                    cnt_next    = cnt_reg - 1'b1;
                    lat_en_next = en_decode;
                end
            end
            ST_HOLD: begin
                if (cnt_reg == '0) begin
                    state_next        = ST_ACK;
                    ack_next[win_reg] = 1'b1;
                    err_next          = err_rec_reg;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_ACK: begin
                state_next = ST_IDLE;
                ptr_next   = (win_reg == PW'(NREQ - 1)) ? '0 : win_reg + 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            ptr_reg      <= '0;
            win_reg      <= '0;
            addr_cap_reg <= '0;
            err_rec_reg  <= 1'b0;
            ack_reg      <= '0;
            err_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            lat_d_reg    <= '0;
            lat_en_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            ptr_reg      <= ptr_next;
            win_reg      <= win_next;
            addr_cap_reg <= addr_cap_next;
            err_rec_reg  <= err_rec_next;
            ack_reg      <= ack_next;
            err_reg      <= err_next;
            busy_reg     <= busy_next;
            lat_d_reg    <= lat_d_next;
            lat_en_reg   <= lat_en_next;
        end
    end

    assign ack    = ack_reg;
    assign err    = err_reg;
    assign busy   = busy_reg;
    assign lat_d  = lat_d_reg;
    assign lat_en = lat_en_reg;

endmodule

// File: tb/tb_latch_wr_arbiter.sv
// Bench for latch_wr_arbiter: vector table, directed corner sequences on three
// parameterisations, and random traffic against a transaction-level model.
module tb_latch_wr_arbiter;

    localparam int S_CYC = 1;
    localparam int O_CYC = 1;
    localparam int H_CYC = 1;
    localparam int TOT   = S_CYC + O_CYC + H_CYC + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [3:0]  req_a = '0, req_b = '0, req_c = '0;
    logic [7:0]  addr_a = '0, addr_b = '0, addr_c = '0;
    logic [31:0] wdata_a = '0, wdata_b = '0, wdata_c = '0;

    logic [3:0] ack_a, ack_b, ack_c;
    logic       err_a, err_b, err_c;
    logic       busy_a, busy_b, busy_c;
    logic [7:0] lat_d_a, lat_d_b, lat_d_c;
    logic [3:0] lat_en_a, lat_en_c;
    logic [2:0] lat_en_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    latch_wr_arbiter #(.NREQ(4), .NLATCH(4), .DW(8), .AW(2),
                       .SETUP_CYC(S_CYC), .OPEN_CYC(O_CYC), .HOLD_CYC(H_CYC)) u_dut_a (
        .clk(clk), .rst(rst), .req(req_a), .addr(addr_a), .wdata(wdata_a),
        .ack(ack_a), .err(err_a), .busy(busy_a), .lat_d(lat_d_a), .lat_en(lat_en_a));

    latch_wr_arbiter #(.NREQ(4), .NLATCH(3), .DW(8), .AW(2),
                       .SETUP_CYC(1), .OPEN_CYC(1), .HOLD_CYC(1)) u_dut_b (
        .clk(clk), .rst(rst), .req(req_b), .addr(addr_b), .wdata(wdata_b),
        .ack(ack_b), .err(err_b), .busy(busy_b), .lat_d(lat_d_b), .lat_en(lat_en_b));

    latch_wr_arbiter #(.NREQ(4), .NLATCH(4), .DW(8), .AW(2),
                       .SETUP_CYC(2), .OPEN_CYC(3), .HOLD_CYC(2)) u_dut_c (
        .clk(clk), .rst(rst), .req(req_c), .addr(addr_c), .wdata(wdata_c),
        .ack(ack_c), .err(err_c), .busy(busy_c), .lat_d(lat_d_c), .lat_en(lat_en_c));

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  ack;
        logic        err;
        logic        busy;
        logic [3:0]  lat_en;
        logic [7:0]  lat_d;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_row(input logic r, input logic [3:0] rq, input logic [7:0] ad,
                           input logic [31:0] wd, input logic [3:0] ak, input logic er,
                           input logic bz, input logic [3:0] en, input logic [7:0] d);
        vec_t v;
        v.rst = r; v.req = rq; v.addr = ad; v.wdata = wd;
        v.ack = ak; v.err = er; v.busy = bz; v.lat_en = en; v.lat_d = d;
        vecs.push_back(v);
    endtask

    // One default-timing transaction: four busy cycles then the idle cycle after ack.
    task automatic add_txn(input logic [3:0] rq, input logic [7:0] ad, input logic [31:0] wd,
                           input int win, input int a, input logic [7:0] d);
        logic [3:0] en;
        logic [3:0] ak;
        en = (a < 4) ? (4'b0001 << a) : 4'b0000;
        ak = 4'b0001 << win;
        add_row(1'b0, rq, ad, wd, 4'b0, 1'b0, 1'b1, 4'b0, d);
        add_row(1'b0, rq, ad, wd, 4'b0, 1'b0, 1'b1, en,   d);
        add_row(1'b0, rq, ad, wd, 4'b0, 1'b0, 1'b1, 4'b0, d);
        add_row(1'b0, rq, ad, wd, ak,   1'b0, 1'b1, 4'b0, d);
        add_row(1'b0, rq, ad, wd, 4'b0, 1'b0, 1'b0, 4'b0, d);
    endtask

    // Reference model: elapsed cycles since grant, round-robin pointer.
    int          m_phase, m_ptr, m_win, m_addr;
    logic [7:0]  m_lat_d;

    task automatic model_step(input logic r, input logic [3:0] rq, input logic [7:0] ad,
                              input logic [31:0] wd);
        if (r) begin
            m_phase = 0; m_ptr = 0; m_lat_d = 8'h00;
        end else if (m_phase == 0) begin
            if (rq != 4'b0) begin
                for (int k = 3; k >= 0; k--)
                    if (rq[(m_ptr + k) % 4]) m_win = (m_ptr + k) % 4;
                m_addr  = int'(ad[2*m_win +: 2]);
                m_lat_d = wd[8*m_win +: 8];
                m_phase = 1;
            end
        end else if (m_phase == TOT) begin
            m_phase = 0;
            m_ptr   = (m_win + 1) % 4;
        end else begin
            m_phase++;
        end
    endtask

    initial begin
        logic        r_rst;
        logic [3:0]  r_req;
        logic [7:0]  r_addr;
        logic [31:0] r_wdata;
        logic [3:0]  e_ack, e_en;
        logic        e_err;

        // Vector table
        add_row(1'b1, 4'b0, 8'h00, 32'h0, 4'b0, 1'b0, 1'b0, 4'b0, 8'h00);
        add_row(1'b1, 4'b0, 8'h00, 32'h0, 4'b0, 1'b0, 1'b0, 4'b0, 8'h00);
        add_txn(4'b0001, 8'h02, 32'h0000_00A5, 0, 2, 8'hA5);
        add_row(1'b0, 4'b0, 8'h00, 32'h0, 4'b0, 1'b0, 1'b0, 4'b0, 8'hA5);
        add_txn(4'b0100, 8'h10, 32'h003C_0000, 2, 1, 8'h3C);
        add_txn(4'b0101, 8'h13, 32'h003C_005A, 0, 3, 8'h5A);
        add_row(1'b1, 4'b0, 8'h00, 32'h0, 4'b0, 1'b0, 1'b0, 4'b0, 8'h00);
        for (int k = 0; k < 5; k++)
            add_txn(4'b1111, 8'h1B, 32'h4433_2211, k % 4, 3 - (k % 4), 8'(8'h11 * ((k % 4) + 1)));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; req_a = vecs[i].req; addr_a = vecs[i].addr; wdata_a = vecs[i].wdata;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), {46'b0, ack_a, err_a, busy_a, lat_en_a, lat_d_a},
                  {46'b0, vecs[i].ack, vecs[i].err, vecs[i].busy, vecs[i].lat_en, vecs[i].lat_d});
        end
        $display("[TB] table: %0d vectors applied", vecs.size());

        // Reset during OPEN drops the transaction and the pointer
        req_a = 4'b0010; addr_a = 8'h04; wdata_a = 32'h0000_7700;
        @(posedge clk); #1;
        check("rstopen_setup_busy", busy_a, 1'b1);
        @(posedge clk); #1;
        check("rstopen_en", lat_en_a, 4'b0010);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstopen_after", {ack_a, err_a, busy_a, lat_en_a}, 10'b0);
        rst = 1'b0; req_a = 4'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("rstopen_noack%0d", k), {ack_a, busy_a}, 5'b0);
        end
        req_a = 4'b1111; addr_a = 8'h1B; wdata_a = 32'h4433_2211;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("rstopen_regrant_ack%0d", k), ack_a, (k == 4) ? 4'b0001 : 4'b0000);
        end
        check("rstopen_regrant_d", lat_d_a, 8'h11);
        $display("[TB] reset-in-open: regrant to requester 0 observed at t+4");
        req_a = 4'b0;
        @(posedge clk); #1;

        // Out-of-range and in-range writes on the three-latch bank
        for (int pass = 0; pass < 2; pass++) begin
            req_b = 4'b0001; addr_b = (pass == 0) ? 8'h03 : 8'h02; wdata_b = 32'h0000_00C3;
            for (int k = 1; k <= 4; k++) begin
                @(posedge clk); #1;
                check($sformatf("oor%0d_en%0d", pass, k), lat_en_b,
                      (pass == 1 && k == 2) ? 3'b100 : 3'b000);
                check($sformatf("oor%0d_ackerr%0d", pass, k), {ack_b, err_b},
                      (k == 4) ? {4'b0001, (pass == 0)} : 5'b0);
            end
            $display("[TB] nlatch3 write addr %0d err=%0b", addr_b[1:0], err_b);
            req_b = 4'b0;
            @(posedge clk); #1;
            check($sformatf("oor%0d_idle", pass), {busy_b, err_b, ack_b}, 6'b0);
        end

        // Stretched timing: 2 setup, 3 open, 2 hold
        req_c = 4'b0001; addr_c = 8'h02; wdata_c = 32'h0000_005E;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            check($sformatf("slow_c%0d", k), {46'b0, ack_c, err_c, busy_c, lat_en_c, lat_d_c},
                  {46'b0, (k == 8) ? 4'b0001 : 4'b0000, 1'b0, 1'b1,
                   (k >= 3 && k <= 5) ? 4'b0100 : 4'b0000, 8'h5E});
        end
        $display("[TB] slow write acked at t+8");
        req_c = 4'b0;
        @(posedge clk); #1;
        check("slow_idle", {busy_c, lat_d_c}, {1'b0, 8'h5E});

        // Random traffic against the model
        rst = 1'b1; req_a = 4'b0;
        @(posedge clk); #1;
        model_step(1'b1, 4'b0, 8'h0, 32'h0);
        rst = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            r_rst   = ($urandom_range(0, 49) == 0);
            r_req   = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
            r_addr  = 8'($urandom);
            r_wdata = $urandom;
            rst = r_rst; req_a = r_req; addr_a = r_addr; wdata_a = r_wdata;
            @(posedge clk); #1;
            model_step(r_rst, r_req, r_addr, r_wdata);
            e_en  = (m_phase > S_CYC && m_phase <= S_CYC + O_CYC) ? (4'b0001 << m_addr) : 4'b0;
            e_ack = (m_phase == TOT) ? (4'b0001 << m_win) : 4'b0;
            e_err = 1'b0;
            check($sformatf("rand%0d", cyc), {46'b0, ack_a, err_a, busy_a, lat_en_a, lat_d_a},
                  {46'b0, e_ack, e_err, (m_phase != 0), e_en, m_lat_d});
            if (m_phase == TOT)
                $display("[TB] rand txn: requester %0d latch %0d data %02h", m_win, m_addr, m_lat_d);
        end
        rst = 1'b0; req_a = 4'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/latch_wr_arbiter.md
Name: latch_wr_arbiter

Overview:
Arbitrates write access from NREQ requesters to a shared bank of NLATCH level-sensitive D latches (d/en/q cells). Only one latch may be transparent at a time, and data is stable around every transparent window. Each write runs as a SETUP -> OPEN -> HOLD -> ACK sequence. The block sits between requester logic and the latch bank and drives the bank's shared data bus and per-latch enables.

Parameters:
- NREQ, 4: number of requesters; must be >= 2.
- NLATCH, 4: number of latches in the bank.
- DW, 8: data width of each latch.
- AW, 2: latch address width; NLATCH <= 2**AW.
- SETUP_CYC, 1: cycles that lat_d is stable before the enable opens; must be >= 1.
- OPEN_CYC, 1: cycles the enable is held high; must be >= 1.
- HOLD_CYC, 1: cycles that lat_d is held after the enable closes; must be >= 1.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- req, input, NREQ: per-requester write request; level, held until ack.
- addr, input, NREQ*AW: packed target latch address; requester i uses bits [i*AW +: AW].
- wdata, input, NREQ*DW: packed write data; requester i uses bits [i*DW +: DW].
- ack, output, NREQ: one-hot, one-cycle completion pulse to the granted requester.
- err, output, 1: pulses together with ack when the address was out of range.
- busy, output, 1: high in every state except IDLE.
- lat_d, output, DW: shared data bus to the latch d inputs.
- lat_en, output, NLATCH: one-hot latch enables; all zero except in OPEN.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, ack=0, err=0, busy=0, lat_en=0, lat_d=0, rr pointer=0, counters=0.
- FSM states: IDLE, SETUP, OPEN, HOLD, ACK.
- IDLE:
  - If req is nonzero, grant round-robin. Search starts at the rr pointer (index after the last granted requester; 0 after reset).
  - Capture the winner's index, addr and wdata into internal registers; go to SETUP.
- SETUP: lat_d = captured data; lat_en = 0; stay SETUP_CYC cycles.
- OPEN:
  - lat_en[captured addr] = 1, all other bits 0; lat_d unchanged; stay OPEN_CYC cycles.
  - If captured addr >= NLATCH, lat_en stays all zero and the error is recorded.
- HOLD: lat_en = 0; lat_d unchanged; stay HOLD_CYC cycles.
- ACK (one cycle): ack[winner] = 1 and err = recorded error. The rr pointer becomes (winner+1) mod NREQ. Next state is IDLE.
- lat_d keeps its last value in IDLE; it changes only when the next SETUP starts.
- Latency: if a request is sampled in IDLE at cycle t:
  - SETUP covers t+1 .. t+SETUP_CYC.
  - OPEN follows; ack occurs at t+SETUP_CYC+OPEN_CYC+HOLD_CYC+1.
  - The next grant is decided at the following cycle, in IDLE.
  - With defaults, ack comes 4 cycles after the request is sampled, and one write completes every 5 cycles.
- Requests and inputs during a transaction:
  - req is ignored outside IDLE.
  - Dropping req mid-transaction does not abort it; ack is still issued.
  - Changes to addr or wdata after capture have no effect.
- Simultaneous requests: exactly one is granted per IDLE decision. No requester waits more than NREQ-1 other transactions.
- Repeat requests: a requester that keeps req high after its ack is served again only after the round-robin scan passes all others.
- Reset mid-operation (any state): lat_en, ack and err are 0 from the cycle after the reset edge. The FSM returns to IDLE, the pending transaction is dropped with no ack, and the pointer returns to 0.
- Invariants:
  - At most one lat_en bit is high at any time.
  - lat_en is never high in the same cycle that lat_d changes.

Decomposition:
- Package latch_ctrl_pkg holds:
  - the state enum (IDLE, SETUP, OPEN, HOLD, ACK);
  - a function computing the counter width as clog2 of the maximum of SETUP_CYC, OPEN_CYC and HOLD_CYC.
- Sub-module rr_arbiter (parameter N):
  - inputs: req, ptr;
  - outputs: one-hot gnt and a binary index;
  - purely combinational; the FSM owns the pointer register.
- All remaining logic lives in latch_wr_arbiter: FSM, single shared down-counter, capture registers, enable decode.

Test Plan:
- Single write: req=0001, addr0=2, wdata0=0xA5, defaults -> lat_d=0xA5 from t+1; lat_en=0100 at t+2 only; ack=0001 at t+4 with err=0; busy high t+1..t+4.
- Contention: req=1111 held continuously -> ack order 0,1,2,3,0 at cycles t+4, t+9, t+14, t+19, t+24. Each lat_en pulse is 1 cycle and targets the matching addr.
- Pointer fairness: requester 2 is served; then req=0101 -> requester 0 is granted next (scan wraps from 3 to 0), not requester 2.
- Out-of-range address: NLATCH=3, addr=3 -> lat_en stays 000 throughout; ack and err both pulse at t+4.
- Reset in OPEN: assert rst for 1 cycle while lat_en=0010 -> lat_en=0 next cycle; no ack; busy=0. The next request is granted with the pointer at 0.
- Parameter variant SETUP_CYC=2, OPEN_CYC=3, HOLD_CYC=2 -> lat_en high for exactly 3 cycles; lat_d stable from 2 cycles before until 2 cycles after the window; ack at t+8.
